// File: rtl/acs_pmu_array_if.sv
// ---------------------------------------------------------------------------
// acs_pmu_array_if
// Bundles the trellis-step input bus and the decision/metric output bus of
// acs_pmu_array.
//   master : drives start_i, bm_valid_i, bm0_i, bm1_i; observes the outputs
//   slave  : the ACS array itself
// Signals:
//   start_i      reinitialise trellis to state 0
//   bm_valid_i   one trellis step offered this cycle
//   bm0_i/bm1_i  per-destination-state branch metrics (slice s = state s)
//   dec_o        survivor decision per state (1 = predecessor p1 chosen)
//   dec_valid_o  one-cycle pulse per accepted step
//   st_valid_o   per-state reachability flags
//   best_state_o index of minimum-metric valid state
//   best_pm_o    metric of best_state_o
//   norm_o       normalisation applied on this step
// ---------------------------------------------------------------------------
interface acs_pmu_array_if #(
    parameter int N_STATES = 8,
    parameter int BM_W     = 2,
    parameter int PM_W     = 8
);
    localparam int ST_W = $clog2(N_STATES);

    logic                     start_i;
    logic                     bm_valid_i;
    logic [N_STATES*BM_W-1:0] bm0_i;
    logic [N_STATES*BM_W-1:0] bm1_i;
    logic [N_STATES-1:0]      dec_o;
    logic                     dec_valid_o;
    logic [N_STATES-1:0]      st_valid_o;
    logic [ST_W-1:0]          best_state_o;
    logic [PM_W-1:0]          best_pm_o;
    logic                     norm_o;

    modport master (
        output start_i, bm_valid_i, bm0_i, bm1_i,
        input  dec_o, dec_valid_o, st_valid_o, best_state_o, best_pm_o, norm_o
    );

    modport slave (
        input  start_i, bm_valid_i, bm0_i, bm1_i,
        output dec_o, dec_valid_o, st_valid_o, best_state_o, best_pm_o, norm_o
    );
endinterface

// File: rtl/acs_pmu_array.sv
// ---------------------------------------------------------------------------
// acs_pmu_array
// Add-compare-select / path-metric unit for a radix-2 shift-register trellis.
// Predecessors of state s are p0 = 2s mod N_STATES and p1 = 2s+1 mod N_STATES.
// Each accepted step updates every path metric, reachability flag and
// survivor decision, and reports the best (lowest-metric) valid state, all
// with one cycle of latency. Steps may be offered every cycle.
//
// Ports:
//   clk  sole clock, rising edge
//   rst  synchronous active-high reset (overrides start_i and bm_valid_i)
//   bus  acs_pmu_array_if.slave (see interface header for signal list)
//
// Build option:
//   ACS_PMU_NORM_EN  when defined, metrics are renormalised by subtracting
//                    2^(PM_W-1) whenever every valid new metric is at least
//                    that large; norm_o pulses on such steps. When undefined,
//                    metrics simply saturate at 2^PM_W-1 and norm_o is 0.
// ---------------------------------------------------------------------------
module acs_pmu_array #(
    parameter int N_STATES = 8,
    parameter int BM_W     = 2,
    parameter int PM_W     = 8
) (
    input logic           clk,
    input logic           rst,
    acs_pmu_array_if.slave bus
);
    localparam int ST_W = $clog2(N_STATES);

    // Saturating metric add at PM_W+1 bits, clamped to all ones.
    function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a,
                                                input logic [BM_W-1:0] b);
        logic [PM_W:0] sum;
        sum = {1'b0, a} + {{(PM_W + 1 - BM_W){1'b0}}, b};
        return sum[PM_W] ? {PM_W{1'b1}} : sum[PM_W-1:0];
    endfunction

    // Registered trellis state and outputs
    logic [PM_W-1:0]     pm_p1 [N_STATES];
    logic [N_STATES-1:0] st_vld_p1;
    logic [N_STATES-1:0] dec_p1;
    logic [ST_W-1:0]     best_state_p1;
    logic [PM_W-1:0]     best_pm_p1;
    logic                vld_p1;
    logic                norm_p1;

    // Combinational next-step values
    logic [PM_W-1:0]     acs_pm_p0  [N_STATES];
    logic [PM_W-1:0]     pm_p0      [N_STATES];
    logic [N_STATES-1:0] st_vld_p0;
    logic [N_STATES-1:0] dec_p0;
    logic [ST_W-1:0]     best_state_p0;
    logic [PM_W-1:0]     best_pm_p0;
    logic                norm_p0;

    // ---- stage p0: add-compare-select per destination state ----
    for (genvar s = 0; s < N_STATES; s++) begin : g_acs
        localparam int P0 = (2 * s) % N_STATES;
        localparam int P1 = (2 * s + 1) % N_STATES;

        logic [PM_W-1:0] cand0;
        logic [PM_W-1:0] cand1;
        logic            v0;
        logic            v1;
        logic            sel;

        always_comb begin
            cand0 = sat_add(pm_p1[P0], bus.bm0_i[s*BM_W +: BM_W]);
            cand1 = sat_add(pm_p1[P1], bus.bm1_i[s*BM_W +: BM_W]);
            v0    = st_vld_p1[P0];
            v1    = st_vld_p1[P1];
            // Ties go to p0; a lone valid predecessor always wins.
            if (v0 && v1) begin
                sel = (cand0 > cand1);
            end else begin
                sel = v1;
            end
        end

        assign st_vld_p0[s] = v0 | v1;
        assign dec_p0[s]    = (v0 | v1) & sel;
        assign acs_pm_p0[s] = !(v0 | v1) ? '0 : (sel ? cand1 : cand0);
    end

    // Optional renormalisation. All valid metrics >= 2^(PM_W-1) means each
    // has its MSB set, so the subtraction is just clearing that bit.
`ifdef ACS_PMU_NORM_EN
    always_comb begin
        logic all_hi;
        logic any_vld;
        all_hi  = 1'b1;
        any_vld = 1'b0;
        for (int s = 0; s < N_STATES; s++) begin
            if (st_vld_p0[s]) begin
                any_vld = 1'b1;
                if (!acs_pm_p0[s][PM_W-1]) begin
                    all_hi = 1'b0;
                end
            end
        end
        norm_p0 = any_vld & all_hi;
        pm_p0   = acs_pm_p0;
        if (norm_p0) begin
            for (int s = 0; s < N_STATES; s++) begin
                if (st_vld_p0[s]) begin
                    pm_p0[s][PM_W-1] = 1'b0;
                end
            end
        end
    end
`else
    always_comb begin
        norm_p0 = 1'b0;
        pm_p0   = acs_pm_p0;
    end
`endif

    // Best-state search over valid metrics; strict compare keeps lowest index.
    always_comb begin
        logic found;
        found         = 1'b0;
        best_state_p0 = '0;
        best_pm_p0    = '0;
        for (int s = 0; s < N_STATES; s++) begin
            if (st_vld_p0[s] && (!found || (pm_p0[s] < best_pm_p0))) begin
                found         = 1'b1;
                best_state_p0 = ST_W'(s);
                best_pm_p0    = pm_p0[s];
            end
        end
    end

    // ---- stage p1: register step results ----
    always_ff @(posedge clk) begin
        if (rst || bus.start_i) begin
            for (int s = 0; s < N_STATES; s++) begin
                pm_p1[s] <= '0;
            end
            st_vld_p1     <= N_STATES'(1);
            dec_p1        <= '0;
            best_state_p1 <= '0;
            best_pm_p1    <= '0;
            vld_p1        <= 1'b0;
            norm_p1       <= 1'b0;
        end else if (bus.bm_valid_i) begin
            pm_p1         <= pm_p0;
            st_vld_p1     <= st_vld_p0;
            dec_p1        <= dec_p0;
            best_state_p1 <= best_state_p0;
            best_pm_p1    <= best_pm_p0;
            vld_p1        <= 1'b1;
            norm_p1       <= norm_p0;
        end else begin
            vld_p1        <= 1'b0;
            norm_p1       <= 1'b0;
        end
    end

    assign bus.dec_o        = dec_p1;
    assign bus.dec_valid_o  = vld_p1;
    assign bus.st_valid_o   = st_vld_p1;
    assign bus.best_state_o = best_state_p1;
    assign bus.best_pm_o    = best_pm_p1;
    assign bus.norm_o       = norm_p1;

endmodule

// File: doc/acs_pmu_array.md
ACS_PMU_ARRAY -- requirements
Module: acs_pmu_array

Interface
REQ-001 SHALL have parameter N_STATES, default 8, trellis state count (power of 2, 4..64).
REQ-002 SHALL have parameter BM_W, default 2, branch metric width.
REQ-003 SHALL have parameter PM_W, default 8, path metric width (PM_W > BM_W+1).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset: synchronous, active-high.
REQ-006 SHALL have port start_i  input  1  reinitialise trellis to state 0.
REQ-007 SHALL have port bm_valid_i  input  1  one trellis step offered this cycle.
REQ-008 SHALL have port bm0_i  input  N_STATES*BM_W  per-destination-state metric of branch from predecessor p0; slice s = state s.
REQ-009 SHALL have port bm1_i  input  N_STATES*BM_W  same, branch from predecessor p1.
REQ-010 SHALL have port dec_o  output  N_STATES  survivor decision per state (1 = p1 chosen).
REQ-011 SHALL have port dec_valid_o  output  1  dec_o/best outputs valid, one-cycle pulse per step.
REQ-012 SHALL have port st_valid_o  output  N_STATES  per-state reachability flags.
REQ-013 SHALL have port best_state_o  output  log2(N_STATES)  index of minimum-metric valid state.
REQ-014 SHALL have port best_pm_o  output  PM_W  metric of best_state_o.
REQ-015 SHALL have port norm_o  output  1  normalisation applied on this step (pulse, with dec_valid_o).

Function
REQ-016 SHALL define predecessors of state s as p0 = (2s) mod N_STATES, p1 = (2s+1) mod N_STATES.
REQ-017 SHALL, per state, compute cand0 = pm[p0]+bm0[s], cand1 = pm[p1]+bm1[s] at PM_W+1 bits, clamped to 2^PM_W-1.
REQ-018 SHALL select: both preds valid -> p1 only if cand0 > cand1 (tie -> p0); only p1 valid -> p1; only p0 valid -> p0; neither -> dec 0, state invalid, metric 0.
REQ-019 SHALL set next st_valid[s] = st_valid[p0] | st_valid[p1].
REQ-020 SHALL register new metrics, st_valid, dec_o, best outputs on the edge where bm_valid_i=1; latency exactly 1 cycle (dec_valid_o high the following cycle only).
REQ-021 SHALL hold metrics, st_valid, dec_o, best outputs unchanged when bm_valid_i=0; dec_valid_o and norm_o low.
REQ-022 SHALL compute best_state_o over valid new metrics, lowest index on tie.
REQ-023 SHALL accept a new step every cycle (no back-pressure).
REQ-024 SHALL, on start_i=1, load pm all 0, st_valid = only state 0, dec_o 0, best_state_o 0, best_pm_o 0, dec_valid_o 0; start_i overrides simultaneous bm_valid_i (step discarded).

Reset
REQ-025 SHALL, on rst=1 at clock edge, apply the start_i state of REQ-024 plus norm_o 0; rst overrides start_i and bm_valid_i.
REQ-026 SHALL discard any step in flight on mid-run reset; first step after reset computes from initial state.

Configuration
REQ-027 SHALL support macro ACS_PMU_NORM_EN.
REQ-028 SHALL, with ACS_PMU_NORM_EN defined, subtract 2^(PM_W-1) from all valid new metrics when every valid new metric >= 2^(PM_W-1), same cycle, and pulse norm_o; best_pm_o reports post-subtraction value.
REQ-029 SHALL, without ACS_PMU_NORM_EN, perform no subtraction, rely on REQ-017 saturation, and tie norm_o to 0.

Verification (N_STATES=4, BM_W=2, PM_W=8)
REQ-030 SHALL cover: reset, one step bm0=bm1=all 1 -> next cycle st_valid_o=0101, pm[0]=pm[2]=1, dec_o=0000, best_state_o=0, best_pm_o=1, dec_valid_o=1 one cycle.
REQ-031 SHALL cover: tie, both preds valid and cand0==cand1 -> dec bit 0; cand0=5, cand1=4 -> dec bit 1, metric 4.
REQ-032 SHALL cover: with ACS_PMU_NORM_EN, bm all 3 every cycle from reset -> metrics 3k; step 43 registers 1 in all states, norm_o=1 that cycle only.
REQ-033 SHALL cover: without ACS_PMU_NORM_EN, same stimulus -> metrics reach 255 at step 85, stay 255 at step 86, norm_o never 1.
REQ-034 SHALL cover: start_i and bm_valid_i high same cycle mid-run -> next cycle st_valid_o=0001, best_pm_o=0, dec_valid_o=0.
REQ-035 SHALL cover: rst asserted with start_i and bm_valid_i high mid-run -> all outputs at reset values next cycle; bm_valid_i gaps hold outputs stable.
